instr_encoder: RTL and testbench

Streaming RV32I instruction encoder: the inverse of the single-cycle controller's decode. It accepts decoded instruction fields (format kind, funct3, funct7b5, register numbers, immediate) on a valid/ready stream. It packs them into 32-bit instruction words for the subset the controller executes (R-type, I-type ALU, lw, sw, beq, jal) and emits each word with a sequential byte address for writing into instruction memory. Used by the test/boot path to build programs in hardware, and as a round-trip checker against the controller.

---
 rtl/instr_encoder.sv | 174 +++++++++++++++++
 tb/tb_instr_encoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Streaming RV32I field-to-word encoder for the controller's instruction subset.
// One registered output stage; each accepted bundle is tagged with a sequential byte address.
module instr_encoder #(
  parameter int unsigned    AW   = 32,
  parameter logic [AW-1:0]  BASE = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_kind,
  input  logic [2:0]    in_funct3,
  input  logic          in_funct7b5,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [31:0]   in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [AW-1:0] out_addr,
  output logic [AW-1:0] count,
  output logic          err,
  output logic [AW-1:0] err_addr
);

  localparam logic [2:0] KIND_R      = 3'd0;
  localparam logic [2:0] KIND_I      = 3'd1;
  localparam logic [2:0] KIND_LOAD   = 3'd2;
  localparam logic [2:0] KIND_STORE  = 3'd3;
  localparam logic [2:0] KIND_BRANCH = 3'd4;
  localparam logic [2:0] KIND_JAL    = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0]   NOP       = 32'h0000_0013;
  localparam logic [AW-1:0] ADDR_STEP = AW'(4);

  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_instr_q, out_instr_d;
  logic [AW-1:0] out_addr_q,  out_addr_d;
  logic [AW-1:0] next_addr_q, next_addr_d;
  logic [AW-1:0] count_q,     count_d;
  logic          err_q,       err_d;
  logic [AW-1:0] err_addr_q,  err_addr_d;

  logic          accept;
  logic          out_hs;
  logic [31:0]   enc_instr;
  logic          enc_bad;
  logic          is_shift;
  logic          fits_i12;
  logic          fits_shamt;
  logic          fits_b13;
  logic          fits_j21;
  logic signed [31:0] imm_s;

  assign in_ready = ~clear & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid_q & out_ready;

  assign imm_s      = $signed(in_imm);
  assign is_shift   = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
  assign fits_i12   = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign fits_shamt = (imm_s >= 32'sd0) && (imm_s <= 32'sd31);
  // Branch/jump offsets must also be even; bit 0 is not representable.
  assign fits_b13   = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];
  assign fits_j21   = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm[0];

  always_comb begin
    enc_instr = NOP;
    enc_bad   = 1'b0;
    case (in_kind)
      KIND_R: begin
        enc_instr = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      end
      KIND_I: begin
        if (is_shift) begin
          enc_instr = {1'b0, in_funct7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_I};
          enc_bad   = ~fits_shamt;
        end else begin
          enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
          enc_bad   = ~fits_i12;
        end
      end
      KIND_LOAD: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
        enc_bad   = ~fits_i12;
      end
      KIND_STORE: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        enc_bad   = ~fits_i12;
      end
      KIND_BRANCH: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], OP_BRANCH};
        enc_bad   = ~fits_b13;
      end
      KIND_JAL: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        enc_bad   = ~fits_j21;
      end
      default: begin
        enc_instr = NOP;
        enc_bad   = 1'b1;
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    next_addr_d = next_addr_q;
    count_d     = count_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    if (clear) begin
      // Pending word is dropped; error record survives until reset.
      out_valid_d = 1'b0;
      next_addr_d = BASE;
      count_d     = '0;
    end else begin
      if (out_hs) begin
        count_d     = count_q + AW'(1);
        out_valid_d = 1'b0;
      end
      if (accept) begin
        out_valid_d = 1'b1;
        out_instr_d = enc_instr;
        out_addr_d  = next_addr_q;
        next_addr_d = next_addr_q + ADDR_STEP;
        if (enc_bad) begin
          err_d = 1'b1;
          if (!err_q) err_addr_d = next_addr_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= BASE;
      next_addr_q <= BASE;
      count_q     <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      next_addr_q <= next_addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign count     = count_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table plus stall, error, clear and wrap sequences.
module tb_instr_encoder;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr, count, err_addr;
  logic        err;

  logic        w_in_ready, w_out_valid, w_err;
  logic [31:0] w_out_instr;
  logic [3:0]  w_out_addr, w_count, w_err_addr;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.AW(32), .BASE(32'd0)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .count(count), .err(err), .err_addr(err_addr)
  );

  instr_encoder #(.AW(4), .BASE(4'd8)) dut_w (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(w_in_ready),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr),
    .out_addr(w_out_addr), .count(w_count), .err(w_err), .err_addr(w_err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  kind;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_kind     = v.kind;
    in_funct3   = v.f3;
    in_funct7b5 = v.f7b5;
    in_rd       = v.rd;
    in_rs1      = v.rs1;
    in_rs2      = v.rs2;
    in_imm      = v.imm;
    in_valid    = 1'b1;
  endtask

  function automatic vec_t mk(input logic [2:0] k, input logic [2:0] f3, input logic f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic [31:0] exp);
    vec_t v;
    v.kind = k; v.f3 = f3; v.f7b5 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.exp_instr = exp;
    return v;
  endfunction

  logic [31:0] exp_addr;
  logic [31:0] exp_count;
  logic [31:0] hold_instr, hold_addr, branch_addr;
  vec_t        va, vb;

  initial begin
    tbl[0] = mk(3'd0, 3'b000, 1'b0, 5'd3,  5'd1,  5'd2,  32'd0,          32'h002081B3); // add
    tbl[1] = mk(3'd1, 3'b000, 1'b0, 5'd5,  5'd0,  5'd0,  32'hFFFF_FFFF,  32'hFFF00293); // addi -1
    tbl[2] = mk(3'd3, 3'b010, 1'b0, 5'd0,  5'd1,  5'd2,  32'd8,          32'h0020A423); // sw
    tbl[3] = mk(3'd4, 3'b000, 1'b0, 5'd0,  5'd1,  5'd2,  32'hFFFF_FFF8,  32'hFE208CE3); // beq -8
    tbl[4] = mk(3'd5, 3'b000, 1'b0, 5'd1,  5'd0,  5'd0,  32'd2048,       32'h001000EF); // jal
    tbl[5] = mk(3'd2, 3'b010, 1'b0, 5'd4,  5'd2,  5'd0,  32'd12,         32'h00C12203); // lw
    tbl[6] = mk(3'd1, 3'b101, 1'b1, 5'd6,  5'd7,  5'd0,  32'd3,          32'h4033D313); // srai
    tbl[7] = mk(3'd0, 3'b000, 1'b1, 5'd10, 5'd11, 5'd12, 32'd0,          32'h40C58533); // sub

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(tbl[0]); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr,          32'd0);
    chk("rst_out_addr",  out_addr,           32'd0);
    chk("rst_count",     count,              32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    chk("rst_err_addr",  err_addr,           32'd0);
    chk("rst_w_out_addr", {28'd0, w_out_addr}, 32'd8);

    // Back-to-back stream; a word per cycle with out_ready held high.
    exp_addr = 32'd0;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_instr", i), out_instr, tbl[i].exp_instr);
      chk($sformatf("vec%0d_addr", i),  out_addr,  exp_addr);
      chk($sformatf("vec%0d_ready", i), {31'd0, in_ready}, 32'd1);
      exp_addr += 32'd4;
    end
    in_valid = 1'b0;
    @(negedge clk);
    exp_count = 32'd8;
    chk("stream_count", count, exp_count);
    chk("stream_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("stream_err", {31'd0, err}, 32'd0);

    // Output stall: first word held, second waits upstream.
    out_ready = 1'b0;
    va = tbl[5]; vb = tbl[7];
    drive(va);
    @(negedge clk);
    hold_instr = out_instr; hold_addr = out_addr;
    chk("stall_first_instr", hold_instr, va.exp_instr);
    chk("stall_first_addr",  hold_addr,  exp_addr);
    drive(vb);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk($sformatf("stall%0d_valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall%0d_instr", c), out_instr, va.exp_instr);
      chk($sformatf("stall%0d_addr", c),  out_addr,  exp_addr);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_instr", out_instr, vb.exp_instr);
    chk("release_addr",  out_addr,  exp_addr + 32'd4);
    chk("release_valid", {31'd0, out_valid}, 32'd1);
    chk("release_count", count, exp_count + 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    exp_count += 32'd2;
    exp_addr  += 32'd8;
    chk("release_count2", count, exp_count);
    chk("release_drained", {31'd0, out_valid}, 32'd0);

    // Range errors: odd branch offset then oversized load offset, then illegal kind.
    drive(mk(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd5, 32'h00208263));
    branch_addr = exp_addr;
    @(negedge clk);
    chk("bad_branch_instr", out_instr, 32'h00208263);
    chk("bad_branch_err", {31'd0, err}, 32'd1);
    chk("bad_branch_err_addr", err_addr, branch_addr);
    exp_addr += 32'd4;
    drive(mk(3'd2, 3'b010, 1'b0, 5'd4, 5'd2, 5'd0, 32'd4096, 32'h00012203));
    @(negedge clk);
    chk("bad_load_instr", out_instr, 32'h00012203);
    chk("bad_load_addr",  out_addr,  exp_addr);
    chk("bad_load_err_addr", err_addr, branch_addr);
    exp_addr += 32'd4;
    drive(mk(3'd6, 3'b000, 1'b0, 5'd9, 5'd9, 5'd9, 32'd0, 32'h00000013));
    @(negedge clk);
    chk("illegal_nop", out_instr, 32'h00000013);
    chk("illegal_err_addr", err_addr, branch_addr);
    exp_addr += 32'd4;
    drive(mk(3'd1, 3'b001, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32, 32'h00009093)); // slli shamt 32
    @(negedge clk);
    chk("bad_shift_instr", out_instr, 32'h00009093);
    chk("bad_shift_err", {31'd0, err}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    exp_count += 32'd4;
    chk("err_count", count, exp_count);

    // Clear with a word pending.
    out_ready = 1'b0;
    drive(tbl[1]);
    @(negedge clk);
    chk("pend_valid", {31'd0, out_valid}, 32'd1);
    clear = 1'b1;
    drive(tbl[2]);
    chk("clear_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    clear = 1'b0;
    chk("clear_valid", {31'd0, out_valid}, 32'd0);
    chk("clear_count", count, 32'd0);
    chk("clear_err", {31'd0, err}, 32'd1);
    chk("clear_err_addr", err_addr, branch_addr);
    out_ready = 1'b1;
    @(negedge clk);
    chk("after_clear_instr", out_instr, tbl[2].exp_instr);
    chk("after_clear_addr",  out_addr,  32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("after_clear_count", count, 32'd1);

    // Reset again; the narrow instance must wrap 8, 12, 0.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_err", {31'd0, err}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("wrap%0d_addr", i), {28'd0, w_out_addr}, (i == 0) ? 32'd8 : (i == 1) ? 32'd12 : 32'd0);
      chk($sformatf("wrap%0d_instr", i), w_out_instr, tbl[i].exp_instr);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_count", {28'd0, w_count}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
